// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver recovering 8-N-1 (or 8-E-1) frames into a valid/read holding register.
// Ports: clk, rstN (async active-low), rxClkEn (oversample tick), rx (serial line, idle high),
//        rxRead (consumer pulse) -> rxData, rxValid, rxFrameErr, rxParityErr, rxOverrun (sticky).
// Optional even-parity bit after the data bits is compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 rxClkEn,
  input  logic                 rx,
  input  logic                 rxRead,
  output logic [DATA_BITS-1:0] rxData,
  output logic                 rxValid,
  output logic                 rxFrameErr,
  output logic                 rxParityErr,
  output logic                 rxOverrun
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_e;
  state_e               state_q, state_d;
  logic                 sync1_q, rx_sync_q;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                 valid_q, valid_d, fe_q, fe_d, ov_q, ov_d, commit;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d, pe_q, pe_d;
`endif
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    commit  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    if (rxClkEn) begin
      case (state_q)
        IDLE: if (!rx_sync_q) begin
          state_d = START;
          tick_d  = '0;
        end
        START: if (tick_q == HALF) begin
          // mid start bit: a line back high means the falling edge was a glitch
          state_d = rx_sync_q ? IDLE : DATA;
          tick_d  = '0;
          bit_d   = '0;
        end else tick_d = tick_q + TW'(1);
        DATA: if (tick_q == LAST) begin
          shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          tick_d  = '0;
          bit_d   = bit_q + BW'(1);
`ifdef UART_RX_PARITY_EN
          if (bit_q == BW'(DATA_BITS - 1)) state_d = PARITY;
`else
          if (bit_q == BW'(DATA_BITS - 1)) state_d = STOP;
`endif
        end else tick_d = tick_q + TW'(1);
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick_q == LAST) begin
          par_d   = rx_sync_q;
          tick_d  = '0;
          state_d = STOP;
        end else tick_d = tick_q + TW'(1);
`endif
        STOP: if (tick_q == LAST) begin
          commit  = 1'b1;
          tick_d  = '0;
          // a low stop bit may be a break; wait for the line to rise before hunting a new start
          state_d = rx_sync_q ? IDLE : BRK;
        end else tick_d = tick_q + TW'(1);
        BRK: if (rx_sync_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    data_d  = commit ? shift_q : data_q;
    fe_d    = commit ? ~rx_sync_q : fe_q;
    valid_d = commit | (valid_q & ~rxRead);
    // overrun only when the held byte is overwritten without being read in the same cycle
    ov_d    = ~rxRead & (ov_q | (commit & valid_q));
`ifdef UART_RX_PARITY_EN
    pe_d    = commit ? (^shift_q ^ par_q) : pe_q;
`endif
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync1_q   <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      sync1_q   <= rx;
      rx_sync_q <= sync1_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      pe_q      <= pe_d;
`endif
    end
  end
  assign rxData     = data_q;
  assign rxValid    = valid_q;
  assign rxFrameErr = fe_q;
  assign rxOverrun  = ov_q;
`ifdef UART_RX_PARITY_EN
  assign rxParityErr = pe_q;
`else
  assign rxParityErr = 1'b0;
`endif
endmodule
